// File: rtl/bmd_64_wdma_engine.sv
// Frame-level write-DMA executor: latches a frame request and issues one MWr
// request per TLP to the 64-bit TX engine, raising done once all are accepted.
module bmd_64_wdma_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_rst_i,
    input  logic        wdma_start_i,
    input  logic [39:0] wdma_addr_i,
    input  logic [9:0]  mwr_len_i,
    input  logic [15:0] mwr_count_i,
    output logic        wdma_done_o,
    output logic        tlp_req_o,
    output logic [39:0] tlp_addr_o,
    output logic [9:0]  tlp_len_o,
    output logic        tlp_4dw_o,
    input  logic        tlp_ack_i,
    output logic [15:0] tlp_sent_o,
    output logic [31:0] dma_cycles_o
);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_REQ  = 4'b0010,
        S_GAP  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t      r_state;
    logic        r_done;
    logic        r_req;
    logic [39:0] r_addr;
    logic [9:0]  r_len;
    logic        r_4dw;
    logic [15:0] r_count;
    logic [15:0] r_sent;
    logic [31:0] r_cycles;

    logic [10:0] w_len_eff;
    logic [39:0] w_step;
    logic [39:0] w_next_addr;
    logic [15:0] w_next_sent;
    logic        w_cnt_en;
    logic [31:0] w_cycles_next;

    // A zero length field encodes a full 1024-DW payload.
    assign w_len_eff     = (r_len == 10'd0) ? 11'd1024 : {1'b0, r_len};
    assign w_step        = {27'd0, w_len_eff, 2'b00};
    assign w_next_addr   = r_addr + w_step;
    assign w_next_sent   = r_sent + 16'd1;
    // Cycle counter runs through REQ/GAP and the single DONE cycle before done shows.
    assign w_cnt_en      = (r_state == S_REQ) || (r_state == S_GAP) ||
                           ((r_state == S_DONE) && !r_done);
    assign w_cycles_next = (r_cycles == 32'hFFFF_FFFF) ? r_cycles : (r_cycles + 32'd1);

    // Frame sequencer with all outputs held in registers.
    always_ff @(posedge clk) begin
        if (!rst_n || init_rst_i) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_req    <= 1'b0;
            r_addr   <= 40'd0;
            r_len    <= 10'd0;
            r_4dw    <= 1'b0;
            r_count  <= 16'd0;
            r_sent   <= 16'd0;
            r_cycles <= 32'd0;
        end else begin
            if (w_cnt_en) begin
                r_cycles <= w_cycles_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (wdma_start_i) begin
                        r_addr   <= wdma_addr_i;
                        r_4dw    <= |wdma_addr_i[39:32];
                        r_len    <= mwr_len_i;
                        r_count  <= mwr_count_i;
                        r_sent   <= 16'd0;
                        r_cycles <= 32'd0;
                        r_done   <= 1'b0;
                        r_state  <= (mwr_count_i == 16'd0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    // An ack only counts while our request is actually visible.
                    if (r_req && tlp_ack_i) begin
                        r_req   <= 1'b0;
                        r_addr  <= w_next_addr;
                        r_4dw   <= |w_next_addr[39:32];
                        r_sent  <= w_next_sent;
                        r_state <= (w_next_sent == r_count) ? S_DONE : S_GAP;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                S_GAP: begin
                    r_state <= S_REQ;
                end
                S_DONE: begin
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else if (!wdma_start_i) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign wdma_done_o  = r_done;
    assign tlp_req_o    = r_req;
    assign tlp_addr_o   = r_addr;
    assign tlp_len_o    = r_len;
    assign tlp_4dw_o    = r_4dw;
    assign tlp_sent_o   = r_sent;
    assign dma_cycles_o = r_cycles;

endmodule

// File: tb/tb_bmd_64_wdma_engine.sv
// Directed bench for bmd_64_wdma_engine; drives and samples on the falling edge.
module tb_bmd_64_wdma_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_rst_i;
    logic        wdma_start_i;
    logic [39:0] wdma_addr_i;
    logic [9:0]  mwr_len_i;
    logic [15:0] mwr_count_i;
    logic        wdma_done_o;
    logic        tlp_req_o;
    logic [39:0] tlp_addr_o;
    logic [9:0]  tlp_len_o;
    logic        tlp_4dw_o;
    logic        tlp_ack_i;
    logic [15:0] tlp_sent_o;
    logic [31:0] dma_cycles_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bmd_64_wdma_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_rst_i   (init_rst_i),
        .wdma_start_i (wdma_start_i),
        .wdma_addr_i  (wdma_addr_i),
        .mwr_len_i    (mwr_len_i),
        .mwr_count_i  (mwr_count_i),
        .wdma_done_o  (wdma_done_o),
        .tlp_req_o    (tlp_req_o),
        .tlp_addr_o   (tlp_addr_o),
        .tlp_len_o    (tlp_len_o),
        .tlp_4dw_o    (tlp_4dw_o),
        .tlp_ack_i    (tlp_ack_i),
        .tlp_sent_o   (tlp_sent_o),
        .dma_cycles_o (dma_cycles_o)
    );

    // Returns falling edges waited until req (or done) is high, -1 on timeout.
    task automatic wait_sig(input bit want_done, output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            if ((want_done ? wdma_done_o : tlp_req_o) === 1'b1) begin
                n = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Waits for a request, captures it, acks it three cycles later.
    task automatic do_tlp(output int n, output logic [39:0] a, output logic d, output logic off);
        wait_sig(1'b0, n);
        a = tlp_addr_o;
        d = tlp_4dw_o;
        repeat (2) @(negedge clk);
        tlp_ack_i = 1'b1;
        @(negedge clk);
        tlp_ack_i = 1'b0;
        off = tlp_req_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init_rst_i = 1'b0; wdma_start_i = 1'b0; tlp_ack_i = 1'b0;
        wdma_addr_i = 40'd0; mwr_len_i = 10'd0; mwr_count_i = 16'd0;
        repeat (3) @(negedge clk);
        vectors++; if (wdma_done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", wdma_done_o); end
        vectors++; if (tlp_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", tlp_req_o); end
        vectors++; if (tlp_addr_o !== 40'd0) begin miscompares++; $display("FAIL reset_addr got %h want 0", tlp_addr_o); end
        vectors++; if (tlp_len_o !== 10'd0) begin miscompares++; $display("FAIL reset_len got %h want 0", tlp_len_o); end
        vectors++; if (tlp_4dw_o !== 1'b0) begin miscompares++; $display("FAIL reset_4dw got %b want 0", tlp_4dw_o); end
        vectors++; if (tlp_sent_o !== 16'd0) begin miscompares++; $display("FAIL reset_sent got %0d want 0", tlp_sent_o); end
        vectors++; if (dma_cycles_o !== 32'd0) begin miscompares++; $display("FAIL reset_cycles got %0d want 0", dma_cycles_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int n; logic [39:0] a; logic d; logic off; logic [39:0] exp_a;
        wdma_addr_i = 40'h00_1000_0000; mwr_len_i = 10'd32; mwr_count_i = 16'd4;
        wdma_start_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_a = 40'h00_1000_0000 + 40'(i) * 40'd128;
            do_tlp(n, a, d, off);
            vectors++; if (n !== 2) begin miscompares++; $display("FAIL basic_req_latency tlp %0d got %0d want 2", i, n); end
            vectors++; if (a !== exp_a) begin miscompares++; $display("FAIL basic_addr tlp %0d got %h want %h", i, a, exp_a); end
            vectors++; if (d !== 1'b0) begin miscompares++; $display("FAIL basic_4dw tlp %0d got %b want 0", i, d); end
            vectors++; if (off !== 1'b0) begin miscompares++; $display("FAIL basic_req_drop tlp %0d got %b want 0", i, off); end
        end
        vectors++; if (tlp_len_o !== 10'd32) begin miscompares++; $display("FAIL basic_len got %0d want 32", tlp_len_o); end
        wait_sig(1'b1, n);
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL basic_done_latency got %0d want 1", n); end
        vectors++; if (tlp_sent_o !== 16'd4) begin miscompares++; $display("FAIL basic_sent got %0d want 4", tlp_sent_o); end
        vectors++; if (dma_cycles_o !== 32'd20) begin miscompares++; $display("FAIL basic_cycles got %0d want 20", dma_cycles_o); end
        repeat (3) @(negedge clk);
        vectors++; if (wdma_done_o !== 1'b1) begin miscompares++; $display("FAIL basic_done_held got %b want 1", wdma_done_o); end
        vectors++; if (dma_cycles_o !== 32'd20) begin miscompares++; $display("FAIL basic_cycles_frozen got %0d want 20", dma_cycles_o); end
        wdma_start_i = 1'b0;
        @(negedge clk);
        vectors++; if (wdma_done_o !== 1'b0) begin miscompares++; $display("FAIL basic_done_drop got %b want 0", wdma_done_o); end
        @(negedge clk);
        vectors++; if (tlp_req_o !== 1'b0) begin miscompares++; $display("FAIL basic_idle_req got %b want 0", tlp_req_o); end
    endtask

    task automatic test_addr_crossing();
        int n; logic [39:0] a; logic d; logic off;
        wdma_addr_i = 40'h01_FFFF_FF80; mwr_len_i = 10'd32; mwr_count_i = 16'd2;
        wdma_start_i = 1'b1;
        do_tlp(n, a, d, off);
        vectors++; if (a !== 40'h01_FFFF_FF80 || d !== 1'b1) begin miscompares++; $display("FAIL cross_first got %h/%b want 01ffffff80/1", a, d); end
        do_tlp(n, a, d, off);
        vectors++; if (a !== 40'h02_0000_0000 || d !== 1'b1) begin miscompares++; $display("FAIL cross_second got %h/%b want 0200000000/1", a, d); end
        wait_sig(1'b1, n);
        wdma_start_i = 1'b0;
        @(negedge clk);
        wdma_addr_i = 40'hFF_FFFF_FF80;
        wdma_start_i = 1'b1;
        do_tlp(n, a, d, off);
        vectors++; if (a !== 40'hFF_FFFF_FF80 || d !== 1'b1) begin miscompares++; $display("FAIL wrap_first got %h/%b want ffffffff80/1", a, d); end
        do_tlp(n, a, d, off);
        vectors++; if (a !== 40'h00_0000_0000 || d !== 1'b0) begin miscompares++; $display("FAIL wrap_second got %h/%b want 0000000000/0", a, d); end
        wait_sig(1'b1, n);
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL wrap_done got %0d want 1", n); end
        wdma_start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_len_zero();
        int n; logic [39:0] a; logic d; logic off;
        wdma_addr_i = 40'd0; mwr_len_i = 10'd0; mwr_count_i = 16'd2;
        wdma_start_i = 1'b1;
        do_tlp(n, a, d, off);
        vectors++; if (a !== 40'd0) begin miscompares++; $display("FAIL len0_first got %h want 0", a); end
        vectors++; if (tlp_len_o !== 10'd0) begin miscompares++; $display("FAIL len0_len got %0d want 0", tlp_len_o); end
        do_tlp(n, a, d, off);
        vectors++; if (a !== 40'h00_0000_1000) begin miscompares++; $display("FAIL len0_second got %h want 1000", a); end
        wait_sig(1'b1, n);
        wdma_start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_count_zero();
        int n; bit req_seen;
        n = -1; req_seen = 1'b0;
        wdma_addr_i = 40'h00_4000_0000; mwr_len_i = 10'd4; mwr_count_i = 16'd0;
        wdma_start_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (tlp_req_o === 1'b1) req_seen = 1'b1;
            if (wdma_done_o === 1'b1) begin n = i; break; end
            @(negedge clk);
        end
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL cnt0_done_latency got %0d want 2", n); end
        vectors++; if (req_seen !== 1'b0) begin miscompares++; $display("FAIL cnt0_req got %b want 0", req_seen); end
        vectors++; if ((dma_cycles_o <= 32'd2) !== 1'b1) begin miscompares++; $display("FAIL cnt0_cycles got %0d want <=2", dma_cycles_o); end
        vectors++; if (tlp_sent_o !== 16'd0) begin miscompares++; $display("FAIL cnt0_sent got %0d want 0", tlp_sent_o); end
        wdma_start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_init_reset();
        int n; logic [39:0] a; logic d; logic off; logic [39:0] exp_a;
        wdma_addr_i = 40'h00_0000_2000; mwr_len_i = 10'd16; mwr_count_i = 16'd5;
        wdma_start_i = 1'b1;
        do_tlp(n, a, d, off);
        do_tlp(n, a, d, off);
        wait_sig(1'b0, n);
        init_rst_i = 1'b1;
        @(negedge clk);
        vectors++; if (tlp_req_o !== 1'b0) begin miscompares++; $display("FAIL irst_req got %b want 0", tlp_req_o); end
        vectors++; if (tlp_sent_o !== 16'd0) begin miscompares++; $display("FAIL irst_sent got %0d want 0", tlp_sent_o); end
        vectors++; if (tlp_addr_o !== 40'd0) begin miscompares++; $display("FAIL irst_addr got %h want 0", tlp_addr_o); end
        init_rst_i = 1'b0;
        wdma_start_i = 1'b0;
        @(negedge clk);
        wdma_start_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_a = 40'h00_0000_2000 + 40'(i) * 40'd64;
            do_tlp(n, a, d, off);
            vectors++; if (a !== exp_a) begin miscompares++; $display("FAIL irst_rerun_addr tlp %0d got %h want %h", i, a, exp_a); end
        end
        wait_sig(1'b1, n);
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL irst_rerun_done got %0d want 1", n); end
        vectors++; if (tlp_sent_o !== 16'd5) begin miscompares++; $display("FAIL irst_rerun_sent got %0d want 5", tlp_sent_o); end
        wdma_start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_spurious_ack();
        int n; logic [39:0] a; logic d; logic off;
        tlp_ack_i = 1'b1;
        @(negedge clk);
        tlp_ack_i = 1'b0;
        vectors++; if (tlp_sent_o !== 16'd5) begin miscompares++; $display("FAIL spur_idle_sent got %0d want 5", tlp_sent_o); end
        wdma_addr_i = 40'h00_0000_3000; mwr_len_i = 10'd8; mwr_count_i = 16'd3;
        wdma_start_i = 1'b1;
        do_tlp(n, a, d, off);
        tlp_ack_i = 1'b1;
        mwr_count_i = 16'd1;
        @(negedge clk);
        tlp_ack_i = 1'b0;
        vectors++; if (tlp_sent_o !== 16'd1) begin miscompares++; $display("FAIL spur_gap_sent got %0d want 1", tlp_sent_o); end
        do_tlp(n, a, d, off);
        vectors++; if (a !== 40'h00_0000_3020) begin miscompares++; $display("FAIL spur_addr2 got %h want 3020", a); end
        do_tlp(n, a, d, off);
        vectors++; if (a !== 40'h00_0000_3040) begin miscompares++; $display("FAIL spur_addr3 got %h want 3040", a); end
        wait_sig(1'b1, n);
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL spur_done got %0d want 1", n); end
        vectors++; if (tlp_sent_o !== 16'd3) begin miscompares++; $display("FAIL spur_sent got %0d want 3", tlp_sent_o); end
        wdma_start_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_addr_crossing();
        test_len_zero();
        test_count_zero();
        test_init_reset();
        test_spurious_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bmd_64_wdma_engine.md
# bmd_64_wdma_engine

Frame-level write-DMA executor that sits between the write-DMA control FSM and the 64-bit TX TLP engine. On a start request it latches a 40-bit host address and a frame geometry (TLP length × TLP count), then issues one memory-write request per TLP to the TX engine, advancing the address after each acceptance. When every TLP of the frame has been accepted, it signals done. It is the responder side of the wdma start/done handshake.

## Interface
Parameters:
- none

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous, active-low reset
- init_rst_i  input  1  soft reset from control registers; same effect as rst_n
- wdma_start_i  input  1  frame request, level; held high by the initiator until it sees wdma_done_o
- wdma_addr_i  input  40  frame base byte address, sampled at start
- mwr_len_i  input  10  TLP payload in DW; 0 encodes 1024 DW
- mwr_count_i  input  16  TLPs per frame
- wdma_done_o  input-facing output  1  frame complete; level, held until wdma_start_i falls
- tlp_req_o  output  1  request one MWr TLP
- tlp_addr_o  output  40  byte address of the requested TLP
- tlp_len_o  output  10  payload DW of the requested TLP (latched mwr_len)
- tlp_4dw_o  output  1  1 when tlp_addr_o[39:32] != 0 (64-bit header)
- tlp_ack_i  input  1  TX engine accepted the request; one-cycle pulse, valid only while tlp_req_o=1
- tlp_sent_o  output  16  TLPs accepted in the current/last frame
- dma_cycles_o  output  32  clk cycles from start acceptance to done, saturating at 0xFFFF_FFFF

## Operation
- States: IDLE, REQ, GAP, DONE (one-hot, 4 bits).
- IDLE: wdma_start_i=1 → latch addr, len, count; clear tlp_sent_o and dma_cycles_o; if latched count=0 → DONE, else → REQ.
- REQ: tlp_req_o=1. On tlp_ack_i: tlp_req_o←0, tlp_addr_o += 4×len_eff (len_eff = 1024 if len=0), tlp_sent_o+1; if new tlp_sent_o = count → DONE, else → GAP.
- GAP: one idle cycle, → REQ.
- DONE: wdma_done_o=1; wdma_start_i=0 → wdma_done_o←0, → IDLE.
- Address arithmetic is 40-bit modulo 2^40; wrap past 0xFF_FFFF_FFFF silently continues from 0; tlp_4dw_o tracks the current address.
- mwr_len_i, mwr_count_i and wdma_addr_i changes after latching are ignored until the next frame.
- wdma_start_i falling during REQ/GAP is ignored; the frame completes and done is raised, then dropped on the first cycle start is low.
- tlp_ack_i while tlp_req_o=0 is ignored.
- dma_cycles_o increments every cycle in REQ/GAP/DONE-before-first-done-cycle; frozen from entering DONE until next start.
- init_rst_i or rst_n low: all outputs and state return to reset values next edge, including mid-TLP (tlp_req_o drops; TX engine owns cleanup of any partial TLP).

## Timing
- Reset values: state IDLE, wdma_done_o 0, tlp_req_o 0, tlp_addr_o 0, tlp_len_o 0, tlp_4dw_o 0, tlp_sent_o 0, dma_cycles_o 0.
- All outputs registered.
- start seen high at edge N → tlp_req_o=1 and tlp_addr_o=base after edge N+1.
- ack at edge M → tlp_req_o=0 after M; next request with updated address after M+2 (one GAP cycle). Minimum TLP spacing 2 cycles + ack latency.
- Last ack at edge M → wdma_done_o=1 after M+1... specifically: state DONE after M, wdma_done_o visible after M+1.
- count=0: wdma_done_o high two edges after start sampled, no TLPs issued.
- start low at edge K while in DONE → wdma_done_o=0 after K; new start accepted no earlier than edge K+1.

## Test plan
- Base 0x00_1000_0000, len 32, count 4, ack 3 cycles after each req → four requests at 0x1000_0000/0080/0100/0180, tlp_4dw_o=0, tlp_sent_o=4, done held until start drops, then IDLE.
- Base 0x01_FFFF_FF80, len 32, count 2 → addresses 0x01_FFFF_FF80, 0x02_0000_0000, tlp_4dw_o=1 both; base 0xFF_FFFF_FF80 count 2 → second address 0x00_0000_0000, tlp_4dw_o=0.
- len 0, count 2, base 0 → tlp_len_o=0, second address 0x1000 (4096 bytes step).
- count 0 → no tlp_req_o pulse, done two cycles after start, dma_cycles_o≤2.
- init_rst_i asserted while tlp_req_o=1 after 2 of 5 acks → next cycle tlp_req_o=0, tlp_sent_o=0, state IDLE; fresh start runs full 5 TLPs.
- Spurious tlp_ack_i in GAP and IDLE, and mwr_count_i changed mid-frame → tlp_sent_o unaffected, frame ends at originally latched count.
